// File: rtl/mips_def_pkg.sv
// Shared MIPS core definitions: opcodes, fetch defaults and the fetch buffer entry type.
// FETCH_JUMP_PREDECODE_EN users: is_jump/jump_target decode J-format words.
package mips_def_pkg;

    localparam logic [5:0]  OP_J           = 6'h02;
    localparam logic [5:0]  OP_JAL         = 6'h03;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic is_jump(input logic [31:0] word);
        return (word[31:26] == OP_J) || (word[31:26] == OP_JAL);
    endfunction

    // Target keeps the region bits of the delay-slot address, as the ISA defines.
    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] word);
        logic [31:0] pc_plus4;
        pc_plus4 = pc + 32'd4;
        return {pc_plus4[31:28], word[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer for the fetch stage: registered storage, push/pop/flush, count.
module fetch_fifo
    import mips_def_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH + 1),
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  fetch_entry_t    i_entry,
    input  logic            i_pop,
    input  logic            i_flush,
    output fetch_entry_t    o_head,
    output logic            o_valid,
    output logic [CntW-1:0] o_count
);

    fetch_entry_t    r_mem [DEPTH];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '{default: '0};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            // Storage is left as is; only the occupancy is discarded.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && !i_pop && (r_count == CntW'(DEPTH))));

endmodule

// File: rtl/instr_fetch.sv
// MIPS fetch front end: PC, request/grant issue, in-order response tracking and redirect.
// Optional FETCH_JUMP_PREDECODE_EN redirects on J/JAL words as they are buffered.
module instr_fetch
    import mips_def_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready
);

    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

    logic            r_active;
    logic [31:0]     r_fetch_pc;
    logic [CntW-1:0] r_outstanding;
    logic [CntW-1:0] r_drop_cnt;
    logic [31:0]     r_rq_pc [FIFO_DEPTH];
    logic [PtrW-1:0] r_rq_wr;
    logic [PtrW-1:0] r_rq_rd;

    logic [31:0]     w_fetch_pc_nxt;
    logic [CntW-1:0] w_outstanding_nxt;
    logic [CntW-1:0] w_drop_cnt_nxt;
    logic            w_req;
    logic            w_grant;
    logic            w_keep;
    logic            w_push;
    logic            w_jump;
    logic [31:0]     w_jump_pc;
    logic            w_redirect;
    logic [31:0]     w_redirect_pc;
    logic [31:0]     w_resp_pc;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic            w_fifo_valid;
    logic [CntW-1:0] w_fifo_count;

    function automatic logic [PtrW-1:0] rq_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Response bookkeeping: every rvalid retires the oldest request PC.
    assign w_resp_pc    = r_rq_pc[r_rq_rd];
    assign w_keep       = imem_rvalid && (r_drop_cnt == '0);
    assign w_push       = w_keep && !redirect_valid;
    assign w_push_entry = '{ins: imem_rdata, pc: w_resp_pc};

`ifdef FETCH_JUMP_PREDECODE_EN
    assign w_jump    = w_push && is_jump(imem_rdata);
    assign w_jump_pc = jump_target(w_resp_pc, imem_rdata);
`else
    assign w_jump    = 1'b0;
    assign w_jump_pc = 32'h0;
`endif

    assign w_redirect    = redirect_valid || w_jump;
    assign w_redirect_pc = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : w_jump_pc;

    // Buffered plus in-flight words never exceed the buffer, so responses always fit.
    assign w_req   = r_active && !w_redirect &&
                     (({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < DepthC);
    assign w_grant = w_req && imem_gnt;

    always_comb begin
        w_fetch_pc_nxt    = r_fetch_pc;
        w_outstanding_nxt = r_outstanding;
        w_drop_cnt_nxt    = r_drop_cnt;

        if (w_grant) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
        if (w_grant && !imem_rvalid) begin
            w_outstanding_nxt = r_outstanding + CntW'(1);
        end else if (!w_grant && imem_rvalid) begin
            w_outstanding_nxt = r_outstanding - CntW'(1);
        end

        if (w_redirect) begin
            // No grant is possible here, so this is everything still in flight.
            w_fetch_pc_nxt = w_redirect_pc;
            w_drop_cnt_nxt = w_outstanding_nxt;
        end else if (imem_rvalid && (r_drop_cnt != '0)) begin
            w_drop_cnt_nxt = r_drop_cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= 1'b0;
            r_fetch_pc    <= {RESET_PC[31:2], 2'b00};
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_active      <= 1'b1;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop_cnt    <= w_drop_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rq_pc <= '{default: '0};
            r_rq_wr <= '0;
            r_rq_rd <= '0;
        end else begin
            if (w_grant) begin
                r_rq_pc[r_rq_wr] <= r_fetch_pc;
                r_rq_wr          <= rq_inc(r_rq_wr);
            end
            if (imem_rvalid) begin
                r_rq_rd <= rq_inc(r_rq_rd);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (ins_ready),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign ins_valid = w_fifo_valid;
    assign ins       = w_head.ins;
    assign ins_pc    = w_head.pc;

    rvalid_needs_outstanding_a: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (r_outstanding != '0));

    drop_within_outstanding_a: assert property (@(posedge clk) disable iff (!rst_n)
        r_drop_cnt <= r_outstanding);

    occupancy_cap_a: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) <= DepthC);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed sequences, a redirect vector table and a randomized run
// checked against a program-order stream model and an in-order memory model.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_del    = 0;
    int unsigned n_grants = 0;
    int unsigned cyc      = 0;

    logic [31:0] mq_addr [$];
    int unsigned mq_cyc [$];
    logic [31:0] g_addr [$];
    logic [31:0] del_pc [$];
    logic [31:0] exp_pc;
    bit          rand_lat;
    bit          mem_hold;
    bit          plant_jump;
    bit          chk_stab;
    bit          prev_pending;
    logic [31:0] prev_addr;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_ins;

    typedef struct {
        logic [31:0] rpc;
        bit          hold;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } redir_vec_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (plant_jump && a == 32'h0) return 32'h0800_0040;
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        w[31] = 1'b1;  // opcode >= 32: never J/JAL
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ins_ready      = 1'b0;
        mq_addr.delete();
        mq_cyc.delete();
        g_addr.delete();
        del_pc.delete();
        exp_pc       = 32'h0;
        n_grants     = 0;
        rand_lat     = 1'b0;
        mem_hold     = 1'b0;
        plant_jump   = 1'b0;
        chk_stab     = 1'b1;
        prev_pending = 1'b0;
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_ins_valid", {31'b0, ins_valid}, 32'h0);
        check("rst_ins", ins, 32'h0);
        check("rst_ins_pc", ins_pc, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
    endtask

    // One clock cycle: caller has set gnt/ready/redirect just after the rising edge.
    task automatic step();
        logic [31:0] a;
        logic [31:0] w;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!mem_hold && mq_addr.size() > 0 && mq_cyc[0] < cyc &&
            (!rand_lat || $urandom_range(1, 0) == 1)) begin
            a = mq_addr.pop_front();
            void'(mq_cyc.pop_front());
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(a);
        end
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = ins_valid;
        s_pc    = ins_pc;
        s_ins   = ins;
        if (s_req) check("addr_align", {30'b0, s_addr[1:0]}, 32'h0);
        if (redirect_valid) check("req_in_redirect", {31'b0, s_req}, 32'h0);
        if (chk_stab && prev_pending && !redirect_valid) begin
            check("req_held", {31'b0, s_req}, 32'h1);
            check("addr_held", s_addr, prev_addr);
        end
        prev_pending = s_req && !imem_gnt;
        prev_addr    = s_addr;
        if (s_req && imem_gnt) begin
            mq_addr.push_back(s_addr);
            mq_cyc.push_back(cyc);
            g_addr.push_back(s_addr);
            n_grants++;
        end
        if (mq_addr.size() > 2) check("outstanding_cap", mq_addr.size(), 32'd2);
        if (s_valid && ins_ready) begin
            w = mem_word(exp_pc);
            check("ins_pc", s_pc, exp_pc);
            check("ins", s_ins, w);
            del_pc.push_back(s_pc);
            n_del++;
            exp_pc = exp_pc + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
            if (w[31:26] == 6'h02 || w[31:26] == 6'h03) begin
                a = s_pc + 32'd4;
                exp_pc = {a[31:28], w[25:0], 2'b00};
            end
`endif
        end
        if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_del(input int unsigned n, input int unsigned budget);
        for (int unsigned i = 0; i < budget && del_pc.size() < n; i++) step();
        check("del_count_reached", {31'b0, del_pc.size() >= n}, 32'h1);
    endtask

    redir_vec_t vecs [4];

    initial begin
        int unsigned first;
        int unsigned cnt8;
        bit          found;
        int unsigned del_base;

        vecs[0] = '{rpc: 32'h0000_1003, hold: 1'b1, exp0: 32'h0000_1000, exp1: 32'h0000_1004};
        vecs[1] = '{rpc: 32'hFFFF_FFFE, hold: 1'b1, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000};
        vecs[2] = '{rpc: 32'h0000_0100, hold: 1'b0, exp0: 32'h0000_0100, exp1: 32'h0000_0104};
        vecs[3] = '{rpc: 32'h0000_0002, hold: 1'b0, exp0: 32'h0000_0000, exp1: 32'h0000_0004};

        // Streaming from reset: grant every cycle, 1-cycle response, always ready.
        do_reset();
        imem_gnt  = 1'b1;
        ins_ready = 1'b1;
        first = 0;
        for (int unsigned k = 1; k <= 12; k++) begin
            step();
            if (s_valid && first == 0) first = k;
        end
        check("first_valid_cycle", first, 32'd3);
        check("t1_enough_del", {31'b0, del_pc.size() >= 4}, 32'h1);
        for (int unsigned i = 0; i < 4 && i < del_pc.size(); i++) check("t1_seq", del_pc[i], 4 * i);

        // Backpressure: requests stop after two words, nothing lost on resume.
        do_reset();
        imem_gnt = 1'b1;
        repeat (10) step();
        check("bp_req_low", {31'b0, s_req}, 32'h0);
        check("bp_grants", n_grants, 32'd2);
        ins_ready = 1'b1;
        run_until_del(2, 10);
        if (del_pc.size() >= 2) begin
            check("bp_first", del_pc[0], 32'h0);
            check("bp_second", del_pc[1], 32'h4);
        end

        // Grant withheld for five cycles on the request to 0x8.
        do_reset();
        ins_ready = 1'b1;
        found = 1'b0;
        for (int unsigned i = 0; i < 20 && !found; i++) begin
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
            else begin
                imem_gnt = 1'b1;
                step();
            end
        end
        check("stall_reached", {31'b0, found}, 32'h1);
        imem_gnt = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            check("stall_req", {31'b0, s_req}, 32'h1);
            check("stall_addr", s_addr, 32'h8);
        end
        imem_gnt = 1'b1;
        repeat (6) step();
        cnt8 = 0;
        foreach (g_addr[i]) if (g_addr[i] == 32'h8) cnt8++;
        check("stall_granted_once", cnt8, 32'd1);

        // Redirect vectors: outstanding requests or a full buffer at the redirect.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            imem_gnt = 1'b1;
            mem_hold = vecs[v].hold;
            repeat (5) step();
            if (vecs[v].hold) check("pre_outstanding", mq_addr.size(), 32'd2);
            else check("pre_full_valid", {31'b0, s_valid}, 32'h1);
            mem_hold       = 1'b0;
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].rpc;
            step();
            redirect_valid = 1'b0;
            ins_ready      = 1'b1;
            run_until_del(2, 20);
            if (del_pc.size() >= 2) begin
                check("redir_first", del_pc[0], vecs[v].exp0);
                check("redir_second", del_pc[1], vecs[v].exp1);
            end
        end

        // Two redirects one idle cycle apart: nothing from the first target survives.
        do_reset();
        imem_gnt  = 1'b1;
        ins_ready = 1'b1;
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        del_pc.delete();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        run_until_del(1, 20);
        if (del_pc.size() >= 1) check("double_redir_first", del_pc[0], 32'h0000_0200);

`ifdef FETCH_JUMP_PREDECODE_EN
        // J at 0x0 targets 0x100; the word at 0x4 must never reach the decoder.
        do_reset();
        plant_jump = 1'b1;
        chk_stab   = 1'b0;
        imem_gnt   = 1'b1;
        ins_ready  = 1'b1;
        run_until_del(3, 30);
        if (del_pc.size() >= 3) begin
            check("jump_word", del_pc[0], 32'h0);
            check("jump_target", del_pc[1], 32'h100);
            check("jump_after", del_pc[2], 32'h104);
        end
`endif

        // Randomized traffic with a reset in the middle.
        do_reset();
        rand_lat = 1'b1;
        del_base = n_del;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                rand_lat = 1'b1;
            end
            imem_gnt       = ($urandom_range(9, 0) < 7);
            ins_ready      = ($urandom_range(9, 0) < 6);
            redirect_valid = ($urandom_range(99, 0) < 4);
            redirect_pc    = $urandom;
            step();
        end
        check("random_liveness", {31'b0, (n_del - del_base) >= 200}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front end of the MIPS core. Produces the 32-bit instruction word and its PC for the decoder stage.
- Keeps a PC counter and issues word requests to instruction memory over a request/grant bus with in-order responses.
- Buffers returned words in a 2-entry FIFO and hands them downstream with a valid/ready handshake.
- Redirects on branch/jump from execute, flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on buffered plus outstanding requests.

Ports:
- clk  input  1  core clock; all state on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response data valid; responses arrive in request order, at least 1 cycle after grant.
- imem_rdata  input  32  instruction word.
- redirect_valid  input  1  branch/jump taken; single-cycle pulse.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored and treated as 0.
- ins_valid  output  1  ins/ins_pc valid to the decoder stage.
- ins  output  32  instruction word.
- ins_pc  output  32  address of ins.
- ins_ready  input  1  decoder stage accepts.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req=0; ins_valid=0; ins=0; ins_pc=0.
- Issue:
  - imem_req=1 when (fifo_count + outstanding) < FIFO_DEPTH and no redirect this cycle. imem_addr=fetch_pc.
  - On imem_req&&imem_gnt: fetch_pc += 4, wrapping mod 2^32; outstanding += 1.
  - Once imem_req is raised it stays high with a stable imem_addr until granted, unless a redirect occurs.
- Response:
  - On imem_rvalid: outstanding -= 1.
  - If drop_cnt>0: drop_cnt -= 1 and discard the word.
  - Otherwise push {imem_rdata, pc}. The pc comes from an internal request-PC queue of FIFO_DEPTH entries.
  - Overflow is impossible by the issue rule. An rvalid with outstanding==0 is a protocol error and is flagged by an assertion.
- Output:
  - ins_valid = FIFO non-empty; ins/ins_pc = FIFO head. Output is registered from FIFO storage, with no combinational path from imem_rdata.
  - Pop on ins_valid&&ins_ready.
  - Push and pop in the same cycle are both honoured and the count is unchanged. A push into an empty FIFO is visible the next cycle (1-cycle latency from rvalid to ins_valid).
- Redirect (highest priority):
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - FIFO cleared; ins_valid=0 next cycle. A handshake on the head beat in the same cycle still counts as delivered.
  - drop_cnt = outstanding minus any response consumed this cycle. A response arriving in the redirect cycle is discarded.
  - imem_req is forced to 0 in the redirect cycle, even if a request was pending ungranted (no grant is taken that cycle). Issue resumes the next cycle from the new PC.
  - A new redirect while drop_cnt>0 accumulates: drop_cnt becomes the total outstanding.
- Reset mid-operation clears everything immediately. Memory responses to pre-reset requests must not arrive after rst_n rises; this is the system's responsibility.
- No branch delay slot is modelled: the redirect target is the next delivered instruction.

Optional Feature:
- Macro FETCH_JUMP_PREDECODE_EN.
- When defined:
  - A word pushed with opcode OP_J or OP_JAL triggers an internal redirect to {pc_plus4[31:28], ins[25:0], 2'b00} in the same cycle as the push.
  - The jump word itself is kept in the FIFO. Later outstanding responses are dropped, as for an external redirect.
  - An external redirect_valid in the same cycle wins.
- When undefined: no predecode; jumps are resolved only by redirect_valid. Logic and ports are identical otherwise.

Decomposition:
- MIPS_DEF package:
  - Add FETCH_RESET_PC and typedef fetch_entry_t {logic [31:0] ins; logic [31:0] pc;}.
  - Reuse the existing OP_J/OP_JAL opcode constants.
- One sub-module: fetch_fifo (parameterised depth, fetch_entry_t payload, push/pop/flush, count output).

Test Plan:
- Reset release, memory grants every cycle with 1-cycle response, ins_ready=1 → ins_pc sequence 0x0,0x4,0x8,… and ins equals memory contents, first ins_valid 3 cycles after reset release.
- ins_ready=0 for 10 cycles → imem_req drops after 2 outstanding/buffered; no word lost; resuming delivers 0x0,0x4 in order.
- imem_gnt held low 5 cycles → imem_req and imem_addr=0x8 stay stable throughout; granted once.
- redirect_valid with redirect_pc=0x0000_1003 while 2 requests are outstanding → both responses discarded; next delivered ins_pc=0x0000_1000.
- Two redirects 1 cycle apart (0x100 then 0x200) → nothing from 0x100 is delivered; first ins_pc=0x200.
- (FETCH_JUMP_PREDECODE_EN) word 0x08000040 (J) at pc 0x0 → delivered, then next ins_pc=0x100; the word at 0x4 is never delivered.
